// File: rtl/imem_port_arbiter.sv
// Fetch/data arbiter for a single-ported 1-cycle-latency unified memory.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module imem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_fetch
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_DATA = 2'd2
    } tag_e;

    tag_e rtag_q, rtag_d;
    logic force_if;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_if = (starve_q == 4'(STARVE_MAX)) & if_req;

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req) begin
            starve_d = 4'd0;
        end else if (d_gnt && starve_q != 4'(STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    assign d_gnt       = d_req & ~force_if;
    assign if_gnt      = if_req & ~d_gnt;
    assign stall_fetch = if_req & ~if_gnt;
    assign mem_en      = if_gnt | d_gnt;

    always_comb begin
        mem_addr  = 30'd0;
        mem_we    = 4'd0;
        mem_wdata = 32'd0;
        if (d_gnt) begin
            mem_addr  = d_addr[31:2];
            mem_wdata = d_wdata;
            if (d_we) begin
                mem_we = d_be;
            end
        end else if (if_gnt) begin
            mem_addr = if_addr[31:2];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rtag_q <= TAG_NONE;
        end else begin
            rtag_q <= rtag_d;
        end
    end

    // Stores return nothing, so they leave the tag at NONE.
    always_comb begin
        rtag_d = TAG_NONE;
        if (if_gnt) begin
            rtag_d = TAG_IF;
        end else if (d_gnt && !d_we) begin
            rtag_d = TAG_DATA;
        end
    end

    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = 32'd0;
        d_rdata   = 32'd0;
        unique case (rtag_q)
            TAG_IF: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            TAG_DATA: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
